// File: rtl/tt_sweep_if.sv
// Bundle between the classification host, the function under evaluation
// and the sweep controller.
interface tt_sweep_if #(
  parameter int N_IN = 7
);
  localparam int TT_W = 1 << N_IN;

  logic              start_valid;
  logic              start_ready;
  logic              abort;
  logic [N_IN-1:0]   x_out;
  logic              f_in;
  logic              busy;
  logic              tt_valid;
  logic              tt_ready;
  logic [TT_W-1:0]   tt_data;
  logic [N_IN:0]     ones_count;
  logic              self_dual;
  logic              is_const;

  // Host / function side
  modport master (
    output start_valid, abort, f_in, tt_ready,
    input  start_ready, x_out, busy, tt_valid, tt_data, ones_count,
           self_dual, is_const
  );

  // Sweep controller side
  modport slave (
    input  start_valid, abort, f_in, tt_ready,
    output start_ready, x_out, busy, tt_valid, tt_data, ones_count,
           self_dual, is_const
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives every minterm of an N_IN-input
// combinational block in ascending order, records its output, derives
// self-dual / constant flags and hands the table back over valid/ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start_valid, start_ready high
// SWEEP    | one minterm per SETTLE+1 cycles, sample f_in on last cycle
// CLASSIFY | one cycle to register self_dual / is_const
// DONE     | tt_valid high, results held until tt_ready
module tt_sweep_ctrl #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  tt_sweep_if.slave   bus
);
  localparam int TT_W = 1 << N_IN;
  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);
  localparam logic [N_IN-1:0] X_LAST   = '1;
  localparam logic [N_IN-1:0] X_ONE    = {{(N_IN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SWEEP, CLASSIFY, DONE} state_t;

  state_t            state_q;
  logic [N_IN-1:0]   x_q;
  logic [3:0]        wait_q;
  logic [TT_W-1:0]   tt_q;
  logic [N_IN:0]     ones_q;
  logic              self_dual_q;
  logic              is_const_q;
  logic              valid_q;
  logic              busy_q;

  logic [TT_W-1:0]   tt_d;
  logic [TT_W-1:0]   tt_rev_d;
  logic [N_IN:0]     ones_d;
  logic              self_dual_d;
  logic              is_const_d;

  // Sample update and classification terms derived from the current table
  always_comb begin
    tt_d       = tt_q;
    tt_d[x_q]  = bus.f_in;
    ones_d     = ones_q + {{N_IN{1'b0}}, bus.f_in};
    tt_rev_d   = '0;
    for (int i = 0; i < TT_W; i++) begin
      tt_rev_d[i] = tt_q[TT_W-1-i];
    end
    // Complementing the index maps minterm i onto TT_W-1-i
    self_dual_d = &(tt_q ^ tt_rev_d);
    is_const_d  = (tt_q == '0) || (&tt_q);
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      wait_q      <= '0;
      tt_q        <= '0;
      ones_q      <= '0;
      self_dual_q <= 1'b0;
      is_const_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            tt_q    <= '0;
            ones_q  <= '0;
            x_q     <= '0;
            wait_q  <= SETTLE_W;
            busy_q  <= 1'b1;
            state_q <= SWEEP;
          end
        end
        SWEEP: begin
          if (bus.abort) begin
            x_q     <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            tt_q   <= tt_d;
            ones_q <= ones_d;
            if (x_q == X_LAST) begin
              state_q <= CLASSIFY;
            end else begin
              x_q    <= x_q + X_ONE;
              wait_q <= SETTLE_W;
            end
          end
        end
        CLASSIFY: begin
          if (bus.abort) begin
            x_q     <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            self_dual_q <= self_dual_d;
            is_const_q  <= is_const_d;
            busy_q      <= 1'b0;
            valid_q     <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.tt_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.x_out       = x_q;
  assign bus.busy        = busy_q;
  assign bus.tt_valid    = valid_q;
  assign bus.tt_data     = tt_q;
  assign bus.ones_count  = ones_q;
  assign bus.self_dual   = self_dual_q;
  assign bus.is_const    = is_const_q;
endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer that characterises one combinational N_IN-input, single-output logic block, such as a majority-gate network under classification.
- Sweeps every input minterm into the block in ascending order, samples the output, and builds the full truth table.
- Derives classification flags from the table and returns the result over a valid/ready handshake.
- Sits between the classification host (the job requester) and the combinational function under evaluation.

Parameters:
- N_IN, 7: input width of the evaluated function. Table width TT_W = 2**N_IN is derived, not overridable.
- SETTLE, 0: extra wait cycles after each new x_out before f_in is sampled. Range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  requester asks for a sweep.
- start_ready  out  1  high only in IDLE.
- abort  in  1  cancels a sweep in progress.
- x_out  out  N_IN  registered minterm driven to the function (bit 0 = x0).
- f_in  in  1  output of the function, combinational from x_out.
- busy  out  1  high in SWEEP and CLASSIFY.
- tt_valid  out  1  result available.
- tt_ready  in  1  requester accepts the result.
- tt_data  out  TT_W  truth table; bit i = f(x_out == i).
- ones_count  out  N_IN+1  number of 1s in tt_data.
- self_dual  out  1  f(~x) == ~f(x) for all x.
- is_const  out  1  tt_data is all-0 or all-1.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - x_out, tt_data, ones_count, self_dual, is_const, tt_valid, busy = 0.
  - Internal index and wait counter = 0.
- States: IDLE, SWEEP, CLASSIFY, DONE.
- IDLE:
  - start_ready = 1.
  - On a clock edge with start_valid=1: tt_data = 0, ones_count = 0, x_out = 0, wait counter = SETTLE, go to SWEEP.
- SWEEP:
  - Each minterm occupies exactly SETTLE+1 cycles.
  - While the wait counter is non-zero, decrement it.
  - When it is 0, sample f_in: tt_data[x_out] = f_in and ones_count += f_in.
  - After the sample, if x_out == TT_W-1, go to CLASSIFY. Otherwise x_out += 1 and reload the wait counter to SETTLE.
  - x_out never wraps. It stays at TT_W-1 through CLASSIFY and DONE.
- CLASSIFY (one cycle):
  - Register self_dual = 1 iff tt_data[i] != tt_data[TT_W-1-i] for all i.
  - Register is_const = (tt_data all 0) or (tt_data all 1).
  - Go to DONE.
- DONE:
  - tt_valid = 1.
  - tt_data, ones_count, self_dual and is_const held stable while tt_valid=1 and tt_ready=0.
  - On an edge with tt_ready=1, drop tt_valid and go to IDLE.
  - A new start is accepted no earlier than the cycle after this handshake.
- Latency: tt_valid first asserts TT_W*(SETTLE+1)+1 cycles after the start-accept edge.
- abort:
  - Sampled in SWEEP and CLASSIFY only. Return to IDLE on the next edge with x_out = 0.
  - tt_valid never asserts for that job.
  - tt_data and ones_count are left as-is and are don't-care.
  - Ignored in IDLE and DONE.
- start_valid outside IDLE is ignored and not queued.
- Async reset mid-sweep or in DONE returns everything to reset values immediately. tt_valid drops in the same cycle.
- ones_count is wide enough for TT_W (value 128 for N_IN=7) without overflow.

Test Plan:
- Majority of x0,x1,x2 (x3..x6 ignored), SETTLE=0, start pulse:
  - tt_data = 0xE8 repeated 16 times.
  - ones_count = 64, self_dual = 1, is_const = 0.
  - tt_valid at cycle 129 after accept.
- f_in tied 0:
  - tt_data = 0, ones_count = 0, is_const = 1, self_dual = 0.
- SETTLE=2, f = x6:
  - tt_valid at cycle 385.
  - Upper 64 bits all 1, lower 64 bits all 0.
  - ones_count = 64, self_dual = 1.
  - Monitor confirms x_out holds each value for exactly 3 cycles.
- Backpressure: hold tt_ready=0 for 10 cycles in DONE.
  - Outputs stay stable and tt_valid stays high.
  - start_valid pulses during DONE are ignored.
  - Release tt_ready: returns to IDLE and start_ready = 1.
- Abort when x_out = 50: next cycle state is IDLE, x_out = 0, tt_valid never rises. A following start completes normally.
- Assert rst_n=0 asynchronously at x_out = 90, between clock edges:
  - Outputs go to reset values immediately.
  - After release, a full sweep gives correct results.
